// File: rtl/leds_sweep_decoder_pkg.sv
// Shared definitions for the LED sweep decoder: FSM state encoding and
// error-code values reported on err_code.
package leds_sweep_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MULTI = 2'd1,  // more than one LED lit
    ERR_SKIP  = 2'd2,  // lit LED not adjacent to the expected position
    ERR_RSVD  = 2'd3
  } err_code_t;

endpackage

// File: rtl/leds_sweep_decoder_onehot_index.sv
// Combinational classifier for the LED bus: index of the lit bit plus
// zero / one-hot flags. The index is only meaningful when is_onehot is set.
module leds_sweep_decoder_onehot_index #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] index,
  output logic         is_zero,
  output logic         is_onehot
);

  // Priority encode the lit bit and classify the vector population.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) index = W'(i);
    end
    is_zero   = (vec == '0);
    is_onehot = !is_zero && ((vec & (vec - 1'b1)) == '0);
  end

endmodule

// File: rtl/leds_sweep_decoder.sv
// Receive-side decoder/monitor for the Knight-Rider LED sweep bus.
// Recovers position, direction and sweep count from the one-hot bus and
// flags multi-hot and skipped-step violations with a sticky error.
// Optional feature: define STALL_DETECT_EN to build the no-change stall
// detector; otherwise stalled is tied low and no counter exists.
module leds_sweep_decoder
  import leds_sweep_decoder_pkg::*;
#(
  parameter int N_LEDS       = 8,
  parameter int STALL_CYCLES = 25000000,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_LEDS-1:0]         leds_in,
  input  logic                      clear_err,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      pos_valid,
  output logic                      dir,
  output logic                      step,
  output logic [CNT_W-1:0]          sweep_count,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic                      stalled
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

  if (N_LEDS < 3 || STALL_CYCLES < 2) begin : g_bad_params
    $error("leds_sweep_decoder: N_LEDS must be >= 3 and STALL_CYCLES >= 2");
  end

  state_t            state_q, next_state;
  err_code_t         code_q, next_code;
  logic [N_LEDS-1:0] s_q;
  logic [POS_W-1:0]  pos_q, next_pos;
  logic              pos_valid_q, next_pos_valid;
  logic              dir_q, next_dir;
  logic              step_q, next_step;
  logic [CNT_W-1:0]  count_q, next_count;
  logic              err_q, next_err;

  logic [POS_W-1:0]  idx;
  logic              is_zero, is_onehot;
  logic              change;
  logic              legal, step_dir;
  logic [POS_W:0]    idx_w, pos_w, expected_w;

  leds_sweep_decoder_onehot_index #(.N(N_LEDS), .W(POS_W)) u_onehot (
    .vec       (leds_in),
    .index     (idx),
    .is_zero   (is_zero),
    .is_onehot (is_onehot)
  );

  assign change = (leds_in != s_q);
  // One extra bit keeps +/-1 at the ends from wrapping into a false match.
  assign idx_w      = {1'b0, idx};
  assign pos_w      = {1'b0, pos_q};
  assign expected_w = dir_q ? (pos_w - 1'b1) : (pos_w + 1'b1);

  // Next-state and next-output decode; only bus changes move the FSM.
  always_comb begin
    next_state     = state_q;
    next_code      = code_q;
    next_pos       = pos_q;
    next_pos_valid = pos_valid_q;
    next_dir       = dir_q;
    next_step      = 1'b0;
    next_count     = count_q;
    next_err       = err_q;
    legal          = 1'b0;
    step_dir       = dir_q;

    if (state_q == ST_ERROR && clear_err) begin
      next_state     = ST_IDLE;
      next_pos_valid = 1'b0;
      next_err       = 1'b0;
      next_code      = ERR_NONE;
    end else if (change) begin
      if (state_q != ST_ERROR && !is_zero && !is_onehot) begin
        next_state     = ST_ERROR;
        next_code      = ERR_MULTI;
        next_err       = 1'b1;
        next_pos_valid = 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (is_onehot) begin
              next_state     = ST_ACQUIRE;
              next_pos       = idx;
              next_pos_valid = 1'b1;
            end
          end
          ST_ACQUIRE, ST_TRACK: begin
            if (is_zero) begin
              next_state     = ST_IDLE;
              next_pos_valid = 1'b0;
            end else if (state_q == ST_ACQUIRE &&
                         (idx_w == pos_w + 1'b1 || idx_w + 1'b1 == pos_w)) begin
              legal    = 1'b1;
              step_dir = (idx < pos_q);
            end else if (state_q == ST_TRACK && idx_w == expected_w) begin
              legal = 1'b1;
            end else begin
              next_state     = ST_ERROR;
              next_code      = ERR_SKIP;
              next_err       = 1'b1;
              next_pos_valid = 1'b0;
            end
          end
          default: ;  // ERROR: everything frozen until clear_err
        endcase
      end

      if (legal) begin
        next_state = ST_TRACK;
        next_pos   = idx;
        next_step  = 1'b1;
        if (idx == '0 || idx == POS_LAST) begin
          next_dir = (idx == POS_LAST);  // bounce off the end just reached
          if (count_q != '1) next_count = count_q + 1'b1;
        end else begin
          next_dir = step_dir;
        end
      end
    end
  end

  // State, sample and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      code_q      <= ERR_NONE;
      s_q         <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q     <= next_state;
      code_q      <= next_code;
      s_q         <= leds_in;
      pos_q       <= next_pos;
      pos_valid_q <= next_pos_valid;
      dir_q       <= next_dir;
      step_q      <= next_step;
      count_q     <= next_count;
      err_q       <= next_err;
    end
  end

`ifdef STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_CYCLES);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES - 1);

  logic [STALL_W-1:0] stall_cnt_q;
  logic               stalled_q;
  logic               active, active_next;

  assign active      = (state_q == ST_ACQUIRE) || (state_q == ST_TRACK);
  assign active_next = (next_state == ST_ACQUIRE) || (next_state == ST_TRACK);

  // Count quiet cycles while locked; flag once the limit is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      stalled_q   <= 1'b0;
    end else begin
      if (change || !active || !active_next) begin
        stall_cnt_q <= '0;
      end else if (stall_cnt_q != STALL_MAX) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
        if (stall_cnt_q == STALL_MAX - 1'b1) stalled_q <= 1'b1;
      end
      if (next_step || !active_next) stalled_q <= 1'b0;
    end
  end

  assign stalled = stalled_q;
`else
  assign stalled = 1'b0;
`endif

  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign dir         = dir_q;
  assign step        = step_q;
  assign sweep_count = count_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_leds_sweep_decoder.sv
// Directed bench for leds_sweep_decoder (N_LEDS=8, STALL_CYCLES=16, CNT_W=4).
module tb_leds_sweep_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] leds_in;
  logic       clear_err;
  logic [2:0] pos;
  logic       pos_valid, dir, step, err, stalled;
  logic [3:0] sweep_count;
  logic [1:0] err_code;

  int passed = 0;
  int total  = 0;

`ifdef STALL_DETECT_EN
  localparam logic STALL_ON = 1'b1;
`else
  localparam logic STALL_ON = 1'b0;
`endif

  leds_sweep_decoder #(.N_LEDS(8), .STALL_CYCLES(16), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .leds_in     (leds_in),
    .clear_err   (clear_err),
    .pos         (pos),
    .pos_valid   (pos_valid),
    .dir         (dir),
    .step        (step),
    .sweep_count (sweep_count),
    .err         (err),
    .err_code    (err_code),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  // Apply one bus value (and clear_err) for exactly one rising edge, then
  // settle just after the edge for sampling.
  task automatic drive(input logic [7:0] v, input logic clr);
    @(negedge clk);
    leds_in   = v;
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; leds_in = 8'h00; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    drive(8'h80, 0); drive(8'h40, 0); drive(8'h20, 0);
    total++; if (pos !== 3'd5 || pos_valid !== 1'b1) $display("FAIL pre_reset_track: got pos=%0d pv=%0b expected pos=5 pv=1", pos, pos_valid); else passed++;
    #3 reset = 1'b1;
    leds_in = 8'h00;
    #1;
    total++; if ({pos, pos_valid, dir, step, sweep_count, err, err_code, stalled} !== 14'd0)
      $display("FAIL reset_outputs: got %0h expected 0", {pos, pos_valid, dir, step, sweep_count, err, err_code, stalled});
    else passed++;
    @(negedge clk) reset = 1'b0;
    drive(8'h80, 0);
    total++; if (pos !== 3'd7) $display("FAIL acquire_pos: got %0d expected 7", pos); else passed++;
    total++; if (pos_valid !== 1'b1) $display("FAIL acquire_pos_valid: got %0b expected 1", pos_valid); else passed++;
    total++; if (step !== 1'b0) $display("FAIL acquire_no_step: got %0b expected 0", step); else passed++;
  endtask

  task automatic test_sweep();
    logic [7:0] seq [14] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                             8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    int steps = 0;
    for (int i = 0; i < 14; i++) begin
      drive(seq[i], 0);
      steps += int'(step);
      if (i == 0) begin
        total++; if (dir !== 1'b1) $display("FAIL dir_first_step: got %0b expected 1", dir); else passed++;
      end
      if (i == 6) begin
        total++; if (dir !== 1'b0) $display("FAIL dir_at_bit0: got %0b expected 0", dir); else passed++;
        total++; if (sweep_count !== 4'd1) $display("FAIL count_at_bit0: got %0d expected 1", sweep_count); else passed++;
      end
      if (i == 13) begin
        total++; if (dir !== 1'b1) $display("FAIL dir_at_bit7: got %0b expected 1", dir); else passed++;
      end
    end
    total++; if (steps != 14) $display("FAIL step_pulses: got %0d expected 14", steps); else passed++;
    total++; if (sweep_count !== 4'd2) $display("FAIL count_one_sweep: got %0d expected 2", sweep_count); else passed++;
    for (int k = 0; k < 30; k++)
      for (int i = 0; i < 14; i++) drive(seq[i], 0);
    total++; if (sweep_count !== 4'hf) $display("FAIL count_saturate: got %0d expected 15", sweep_count); else passed++;
    total++; if (pos !== 3'd7 || err !== 1'b0) $display("FAIL long_sweep_end: got pos=%0d err=%0b expected pos=7 err=0", pos, err); else passed++;
  endtask

  task automatic test_skip();
    drive(8'h40, 0); drive(8'h20, 0); drive(8'h10, 0);
    total++; if (pos !== 3'd4 || dir !== 1'b1) $display("FAIL skip_setup: got pos=%0d dir=%0b expected pos=4 dir=1", pos, dir); else passed++;
    drive(8'h04, 0);
    total++; if (err !== 1'b1) $display("FAIL skip_err: got %0b expected 1", err); else passed++;
    total++; if (err_code !== 2'd2) $display("FAIL skip_code: got %0d expected 2", err_code); else passed++;
    total++; if (pos !== 3'd4) $display("FAIL skip_pos_held: got %0d expected 4", pos); else passed++;
    total++; if (step !== 1'b0) $display("FAIL skip_no_step: got %0b expected 0", step); else passed++;
  endtask

  task automatic test_multi();
    drive(8'h18, 0);
    total++; if (err_code !== 2'd2) $display("FAIL code_held_first: got %0d expected 2", err_code); else passed++;
    drive(8'h18, 1);
    total++; if (err !== 1'b0 || err_code !== 2'd0) $display("FAIL clear_err: got err=%0b code=%0d expected err=0 code=0", err, err_code); else passed++;
    drive(8'h40, 0);
    total++; if (pos !== 3'd6 || pos_valid !== 1'b1) $display("FAIL reacquire: got pos=%0d pv=%0b expected pos=6 pv=1", pos, pos_valid); else passed++;
    drive(8'h18, 0);
    total++; if (err !== 1'b1 || err_code !== 2'd1) $display("FAIL multi_code: got err=%0b code=%0d expected err=1 code=1", err, err_code); else passed++;
    drive(8'h20, 1);
    total++; if (err !== 1'b0 || err_code !== 2'd0 || pos_valid !== 1'b0) $display("FAIL clear_priority: got err=%0b code=%0d pv=%0b expected 0 0 0", err, err_code, pos_valid); else passed++;
    drive(8'h20, 0);
    total++; if (pos_valid !== 1'b0 || step !== 1'b0) $display("FAIL clear_change_ignored: got pv=%0b step=%0b expected 0 0", pos_valid, step); else passed++;
  endtask

  task automatic test_stall();
    drive(8'h40, 0);
    drive(8'h20, 0);
    total++; if (step !== 1'b1 || pos !== 3'd5) $display("FAIL stall_setup: got step=%0b pos=%0d expected step=1 pos=5", step, pos); else passed++;
    repeat (14) drive(8'h20, 0);
    total++; if (stalled !== 1'b0) $display("FAIL stall_early: got %0b expected 0", stalled); else passed++;
    drive(8'h20, 0);
    total++; if (stalled !== STALL_ON) $display("FAIL stall_assert: got %0b expected %0b", stalled, STALL_ON); else passed++;
    total++; if (pos !== 3'd5 || err !== 1'b0) $display("FAIL stall_no_err: got pos=%0d err=%0b expected pos=5 err=0", pos, err); else passed++;
    drive(8'h10, 0);
    total++; if (stalled !== 1'b0 || step !== 1'b1 || pos !== 3'd4) $display("FAIL stall_clear: got stalled=%0b step=%0b pos=%0d expected 0 1 4", stalled, step, pos); else passed++;
  endtask

  task automatic test_blank();
    drive(8'h00, 0);
    total++; if (pos_valid !== 1'b0 || err !== 1'b0) $display("FAIL blank_idle: got pv=%0b err=%0b expected 0 0", pos_valid, err); else passed++;
    total++; if (sweep_count !== 4'hf) $display("FAIL blank_count_kept: got %0d expected 15", sweep_count); else passed++;
    drive(8'h08, 0);
    total++; if (pos !== 3'd3 || pos_valid !== 1'b1) $display("FAIL blank_reacquire: got pos=%0d pv=%0b expected 3 1", pos, pos_valid); else passed++;
    drive(8'h20, 0);
    total++; if (err !== 1'b1 || err_code !== 2'd2) $display("FAIL acquire_skip: got err=%0b code=%0d expected 1 2", err, err_code); else passed++;
    drive(8'h00, 0);
    total++; if (err !== 1'b1 || err_code !== 2'd2) $display("FAIL blank_in_error: got err=%0b code=%0d expected 1 2", err, err_code); else passed++;
    drive(8'h08, 0);
    total++; if (err !== 1'b1 || pos !== 3'd3 || pos_valid !== 1'b0) $display("FAIL error_frozen: got err=%0b pos=%0d pv=%0b expected 1 3 0", err, pos, pos_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_skip();
    test_multi();
    test_stall();
    test_blank();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
